// File: rtl/mod_mult.sv
// mod_mult: iterative bit-serial MSB-first modular multiplier, r = (a*b) mod p
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   enable start request, sampled only in IDLE
//   a, b   operands (must be < p), latched at the load edge
//   r      result, valid while done=1 and held until the next completion
//   done   one-cycle pulse marking r valid
//   busy   high while in RUN and DONE
// Optional macro MOD_MULT_SKIP_LZ_EN: start at the highest set bit of b
// (data-dependent latency) instead of always iterating over all width bits.
module mod_mult #(
    parameter int               width = 128,
    parameter logic [width-1:0] p     = width'(37)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] r,
    output logic             done,
    output logic             busy
);
    localparam int kw = $clog2(width);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [width-1:0] a_q, b_q, acc, t;
    logic [kw-1:0]    k, k_load;
    logic [width:0]   pe, dbl, dbl_red, sum;
`ifdef MOD_MULT_SKIP_LZ_EN
    function automatic logic [kw-1:0] msb_idx(input logic [width-1:0] v);
        msb_idx = '0;
        for (int i = 0; i < width; i++)
            if (v[i]) msb_idx = kw'(i);
    endfunction
    // leading zeros of b leave acc at 0, so skipping them is exact
    assign k_load = msb_idx(b);
`else
    assign k_load = kw'(width - 1);
`endif
    // width+1 bit intermediates: 2*acc and acc+a cannot overflow since both < p
    always_comb begin
        pe        = {1'b0, p};
        dbl       = {acc, 1'b0};
        dbl_red   = (dbl >= pe) ? dbl - pe : dbl;
        sum       = dbl_red + {1'b0, a_q};
        t         = b_q[k] ? width'((sum >= pe) ? sum - pe : sum) : width'(dbl_red);
        state_nxt = (state == IDLE) ? (enable ? RUN : IDLE) :
                    (state == RUN)  ? ((k == '0) ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            k     <= '0;
            r     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= state_nxt != IDLE;
            done  <= state_nxt == DONE;
            if (state == IDLE && enable) begin
                a_q <= a;
                b_q <= b;
                acc <= '0;
                k   <= k_load;
            end
            if (state == RUN) begin
                acc <= t;
                if (k == '0) r <= t;
                else k <= k - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mod_mult.sv
// tb_mod_mult: randomized self-checking bench for mod_mult against (a*b)%p
module tb_mod_mult;
    localparam logic [127:0] p_big = {1'b0, {127{1'b1}}};
    logic         clk, rst_n;
    logic         en[2];
    logic [127:0] a_in[2], b_in[2], r[2];
    logic         done[2], busy[2];
    int           n_chk, n_pass;

    mod_mult #(.width(128), .p(128'd37)) u_small (
        .clk(clk), .reset(rst_n), .enable(en[0]), .a(a_in[0]), .b(b_in[0]),
        .r(r[0]), .done(done[0]), .busy(busy[0])
    );
    mod_mult #(.width(128), .p(p_big)) u_big (
        .clk(clk), .reset(rst_n), .enable(en[1]), .a(a_in[1]), .b(b_in[1]),
        .r(r[1]), .done(done[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] model(input int d, input logic [127:0] x, input logic [127:0] y);
        logic [255:0] prod, m;
        m    = {128'd0, (d == 0) ? 128'd37 : p_big};
        prod = {128'd0, x} * {128'd0, y};
        return 128'(prod % m);
    endfunction

    function automatic int lat(input logic [127:0] y);
        lat = 128;
`ifdef MOD_MULT_SKIP_LZ_EN
        lat = 1;
        for (int i = 0; i < 128; i++) if (y[i]) lat = i + 1;
`endif
    endfunction

    // call at the negedge right after the load edge
    task automatic wait_done(input int d, input int n, input logic [127:0] exp);
        int c;
        bit ok;
        c  = 0;
        ok = 1;
        while (!done[d] && c < n + 4) begin
            if (!busy[d]) ok = 0;
            @(negedge clk);
            c++;
        end
        check("busy_run", 128'(ok), 128'd1);
        check("latency", 128'(c), 128'(n));
        check("result", r[d], exp);
        check("busy_done", 128'(busy[d]), 128'd1);
        @(negedge clk);
        check("done_pulse", 128'(done[d]), 128'd0);
        check("busy_idle", 128'(busy[d]), 128'd0);
        check("r_hold", r[d], exp);
    endtask

    task automatic run_op(input int d, input logic [127:0] x, input logic [127:0] y);
        @(negedge clk);
        en[d]   = 1;
        a_in[d] = x;
        b_in[d] = y;
        @(negedge clk);
        en[d]   = 0;
        a_in[d] = {$urandom, $urandom, $urandom, $urandom};
        b_in[d] = {$urandom, $urandom, $urandom, $urandom};
        wait_done(d, lat(y), model(d, x, y));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        logic [127:0] xs, ys, xb, yb;
        clk = 0;
        rst_n = 0;
        n_chk = 0;
        n_pass = 0;
        for (int d = 0; d < 2; d++) begin
            en[d] = 0;
            a_in[d] = '0;
            b_in[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_r", r[d], 128'd0);
            check("rst_done", 128'(done[d]), 128'd0);
            check("rst_busy", 128'(busy[d]), 128'd0);
        end
        rst_n = 1;
        @(negedge clk);
        run_op(0, 128'd20, 128'd30);
        run_op(0, 128'd36, 128'd36);
        run_op(0, 128'd0, 128'd25);
        run_op(0, 128'd5, 128'd0);
        run_op(1, p_big - 1, p_big - 1);
        run_op(1, 128'd1 << 100, 128'd1 << 27);
        // enable held high: operand changes during RUN are ignored, reload after DONE
        @(negedge clk);
        en[0] = 1;
        a_in[0] = 128'd3;
        b_in[0] = 128'd4;
        @(negedge clk);
        a_in[0] = 128'd7;
        b_in[0] = 128'd8;
        wait_done(0, lat(128'd4), 128'd12);
        @(negedge clk);
        check("reload_busy", 128'(busy[0]), 128'd1);
        en[0] = 0;
        a_in[0] = '0;
        b_in[0] = '0;
        wait_done(0, lat(128'd8), 128'd19);
        // asynchronous reset in the middle of an operation
        @(negedge clk);
        en[0] = 1;
        a_in[0] = 128'd20;
        b_in[0] = 128'd30;
        @(negedge clk);
        en[0] = 0;
        repeat (49) @(negedge clk);
        #1 rst_n = 0;
        #1;
        check("async_rst_r", r[0], 128'd0);
        check("async_rst_done", 128'(done[0]), 128'd0);
        check("async_rst_busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1;
        ok = 1;
        repeat (140) begin
            @(negedge clk);
            if (done[0] || busy[0]) ok = 0;
        end
        check("no_done_after_rst", 128'(ok), 128'd1);
        run_op(0, 128'd20, 128'd30);
        for (int i = 0; i < 300; i++) begin
            xs = 128'($urandom_range(36));
            ys = 128'($urandom_range(36));
            xb = {$urandom, $urandom, $urandom, $urandom};
            yb = {$urandom, $urandom, $urandom, $urandom};
            xb[127] = 1'b0;
            yb[127] = 1'b0;
            if (xb == p_big) xb = '0;
            if (yb == p_big) yb = '0;
            fork
                run_op(0, xs, ys);
                run_op(1, xb, yb);
            join
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
